// File: rtl/oled_frame_streamer_pkg.sv
// oled_frame_streamer_pkg: shared display geometry, RGB565 layout, init command ROM and streamer states
package oled_frame_streamer_pkg;
  localparam int OLED_WIDTH = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;
  localparam int RGB565_R_BITS = 5;
  localparam int RGB565_G_BITS = 6;
  localparam int RGB565_B_BITS = 5;
  localparam int RGB565_BITS = RGB565_R_BITS + RGB565_G_BITS + RGB565_B_BITS;
  localparam int INIT_LEN = 10;
  localparam logic [INIT_LEN*8-1:0] INIT_CMDS = 80'hAE_A0_72_15_00_5F_75_00_3F_AF;
  typedef enum logic [2:0] {
    RST_HOLD,
    PWR_WAIT,
    CMD_LOAD,
    CMD_SHIFT,
    IDLE,
    PIX_FETCH,
    PIX_SHIFT
  } state_t;
  function automatic logic [7:0] init_cmd(input logic [3:0] i);
    return INIT_CMDS[8*(INIT_LEN-1-int'(i)) +: 8];
  endfunction
endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: MSB-first SPI serialiser for 8- or 16-bit words, sclk idle high, data launched on falling edge
module spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [4:0]  bits,
  output logic        sclk,
  output logic        sdin,
  output logic        done
);
  localparam int CW = $clog2(CLK_DIV + 1);
  logic [CW-1:0] cnt;
  logic [3:0] bit_left;
  logic [14:0] sreg;
  logic busy;
  logic half_end;
  assign half_end = cnt == CW'(CLK_DIV - 1);
  assign done = busy && sclk && half_end && bit_left == '0;
  // each bit: CLK_DIV cycles low (data already valid), then CLK_DIV cycles high
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy <= 1'b0;
      cnt <= '0;
      bit_left <= '0;
      sreg <= '0;
      sclk <= 1'b1;
      sdin <= 1'b0;
    end else if (load) begin
      busy <= 1'b1;
      cnt <= '0;
      bit_left <= 4'(bits - 5'd1);
      sreg <= bits == 5'd8 ? {data[6:0], 8'h00} : data[14:0];
      sdin <= bits == 5'd8 ? data[7] : data[15];
      sclk <= 1'b0;
    end else if (busy) begin
      cnt <= half_end ? '0 : cnt + 1'b1;
      if (half_end) begin
        if (!sclk) sclk <= 1'b1;
        else if (bit_left == '0) busy <= 1'b0;
        else begin
          sclk <= 1'b0;
          sdin <= sreg[14];
          sreg <= {sreg[13:0], 1'b0};
          bit_left <= bit_left - 4'd1;
        end
      end
    end
endmodule

// File: rtl/oled_frame_streamer.sv
// oled_frame_streamer: SSD1331 power-up, command init and continuous 96x64 RGB565 frame streaming over SPI
module oled_frame_streamer
  import oled_frame_streamer_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int RST_CYCLES = 1000,
  parameter int PWR_CYCLES = 2000,
  parameter int PIX_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [RGB565_BITS-1:0] pixel_data,
  output logic [12:0]            pixel_index,
  output logic                   frame_begin,
  output logic                   sending_pixels,
  output logic                   cs,
  output logic                   sclk,
  output logic                   sdin,
  output logic                   d_cn,
  output logic                   resn,
  output logic                   vccen,
  output logic                   pmoden
);
  state_t state;
  logic [31:0] cnt;
  logic [3:0] cmd_idx;
  logic gap_done, fetch_ready, load, done;
  logic [15:0] data;
  logic [4:0] bits;
  assign gap_done = state == CMD_LOAD && cnt == 32'(2 * CLK_DIV - 1);
  assign fetch_ready = state == PIX_FETCH && cnt == 32'(PIX_LATENCY - 1);
  assign load = gap_done || fetch_ready;
  assign data = state == PIX_FETCH ? pixel_data : {8'h00, init_cmd(cmd_idx)};
  assign bits = state == PIX_FETCH ? 5'd16 : 5'd8;
  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk(clk),
    .reset(reset),
    .load(load),
    .data(data),
    .bits(bits),
    .sclk(sclk),
    .sdin(sdin),
    .done(done)
  );
  // power-up, command init and pixel streaming sequencer; owns cs and d_cn
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RST_HOLD;
      cnt <= '0;
      cmd_idx <= '0;
      pixel_index <= '0;
      frame_begin <= 1'b0;
      sending_pixels <= 1'b0;
      cs <= 1'b1;
      d_cn <= 1'b0;
      resn <= 1'b0;
      vccen <= 1'b0;
      pmoden <= 1'b0;
    end else begin
      frame_begin <= 1'b0;
      cnt <= cnt + 32'd1;
      case (state)
        RST_HOLD: begin
          pmoden <= 1'b1;
          if (cnt == 32'(RST_CYCLES - 1)) begin
            resn <= 1'b1;
            vccen <= 1'b1;
            cnt <= '0;
            state <= PWR_WAIT;
          end
        end
        PWR_WAIT:
          if (cnt == 32'(PWR_CYCLES - 1)) begin
            cnt <= '0;
            state <= CMD_LOAD;
          end
        CMD_LOAD:
          if (gap_done) begin
            cs <= 1'b0;
            d_cn <= 1'b0;
            state <= CMD_SHIFT;
          end
        CMD_SHIFT:
          if (done) begin
            cs <= 1'b1;
            cnt <= '0;
            if (cmd_idx == 4'(INIT_LEN - 1)) state <= IDLE;
            else begin
              cmd_idx <= cmd_idx + 4'd1;
              state <= CMD_LOAD;
            end
          end
        IDLE:
          if (enable) begin
            frame_begin <= pixel_index == '0;
            sending_pixels <= 1'b1;
            d_cn <= 1'b1;
            cnt <= '0;
            state <= PIX_FETCH;
          end
        PIX_FETCH:
          if (fetch_ready) begin
            cs <= 1'b0;
            state <= PIX_SHIFT;
          end
        PIX_SHIFT:
          if (done) begin
            cnt <= '0;
            if (pixel_index == 13'(OLED_PIXELS - 1)) begin
              pixel_index <= '0;
              frame_begin <= 1'b1;
            end else pixel_index <= pixel_index + 13'd1;
            if (enable) state <= PIX_FETCH;
            else begin
              cs <= 1'b1;
              sending_pixels <= 1'b0;
              state <= IDLE;
            end
          end
        default: state <= RST_HOLD;
      endcase
    end
endmodule

// File: tb/tb_oled_frame_streamer.sv
// tb_oled_frame_streamer: scoreboard bench decoding the SPI stream against expected init bytes and pixel words
module tb_oled_frame_streamer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [15:0] pixel_data = '0;
  logic [12:0] pixel_index;
  logic frame_begin, sending_pixels, cs, sclk, sdin, d_cn, resn, vccen, pmoden;
  typedef struct packed {logic dc; logic [15:0] val;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_checks = 0;
  int n_fail = 0;
  int nbits = 0;
  int words = 0;
  int fb_cnt = 0;
  int exp_idx = 0;
  logic [15:0] sh = '0;
  logic [7:0] init_bytes [10] = '{8'hAE, 8'hA0, 8'h72, 8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F, 8'hAF};
  localparam int LIMIT = 5000;

  oled_frame_streamer #(.CLK_DIV(2), .RST_CYCLES(4), .PWR_CYCLES(4), .PIX_LATENCY(2)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pixel_data(pixel_data),
    .pixel_index(pixel_index),
    .frame_begin(frame_begin),
    .sending_pixels(sending_pixels),
    .cs(cs),
    .sclk(sclk),
    .sdin(sdin),
    .d_cn(d_cn),
    .resn(resn),
    .vccen(vccen),
    .pmoden(pmoden)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pixel_data <= {pixel_index, 3'b101};

  always @(negedge clk) if (frame_begin) fb_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge sclk or posedge cs or posedge reset)
    if (reset) begin
      nbits = 0;
      sh = '0;
    end else if (cs) begin
      check("whole_word", 32'(nbits), 32'd0);
      nbits = 0;
    end else begin
      sh = {sh[14:0], sdin};
      nbits++;
      if (nbits == (d_cn ? 16 : 8)) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("spi_word", 32'({d_cn, sh}), 32'(e));
        end else check("spi_unexpected", 32'({d_cn, sh}), 32'hFFFF_FFFF);
        words++;
        nbits = 0;
        sh = '0;
      end
    end

  task automatic push_init();
    for (int i = 0; i < 10; i++) sb.push_back('{1'b0, {8'h00, init_bytes[i]}});
  endtask

  task automatic push_pix(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{1'b1, {13'(exp_idx), 3'b101}});
      exp_idx = exp_idx == 6143 ? 0 : exp_idx + 1;
    end
  endtask

  task automatic wait_bits(input int w, input int b);
    int n = 0;
    while (!(words == w && nbits == b) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("wait_bits_in_time", 32'(n < LIMIT), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(sb.size() == 0 && cs && !sending_pixels) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_in_time", 32'(n < LIMIT), 32'd1);
  endtask

  initial begin
    #500000;
    $display("watchdog expired at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({pixel_index, frame_begin, sending_pixels, cs, sclk, sdin, d_cn, resn, vccen, pmoden}),
          32'({13'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    push_init();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("resn_vccen_pmoden", 32'({resn, vccen, pmoden}), i < 3 ? 32'b001 : 32'b111);
    end
    wait_idle();
    check("idle_after_init", 32'({cs, sclk, d_cn, sending_pixels}), 32'b1100);
    exp_idx = 0;
    push_pix(3);
    enable = 1'b1;
    wait_bits(12, 5);
    check("streaming_lines", 32'({sending_pixels, cs, d_cn}), 32'b101);
    enable = 1'b0;
    wait_idle();
    check("pause_index", 32'(pixel_index), 32'(exp_idx));
    check("first_frame_begin", 32'(fb_cnt), 32'd1);
    push_pix(2);
    enable = 1'b1;
    wait_bits(14, 5);
    enable = 1'b0;
    wait_idle();
    check("resume_index", 32'(pixel_index), 32'(exp_idx));
    check("resume_no_frame_begin", 32'(fb_cnt), 32'd1);
    push_pix(1);
    enable = 1'b1;
    wait_bits(15, 2);
    @(negedge clk);
    force dut.pixel_index = 13'd6142;
    @(negedge clk);
    release dut.pixel_index;
    exp_idx = 6143;
    push_pix(3);
    wait_bits(18, 5);
    enable = 1'b0;
    wait_idle();
    check("wrap_index", 32'(pixel_index), 32'(exp_idx));
    check("wrap_frame_begin", 32'(fb_cnt), 32'd2);
    push_pix(1);
    enable = 1'b1;
    wait_bits(19, 9);
    #1 reset = 1'b1;
    sb.delete();
    #1 check("async_reset", 32'({cs, sclk, resn, sdin, sending_pixels, pixel_index}), 32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'd0}));
    enable = 1'b0;
    exp_idx = 0;
    repeat (2) @(negedge clk);
    push_init();
    reset = 1'b0;
    wait_idle();
    check("idle_after_reinit", 32'({cs, sclk, d_cn, resn, vccen, pmoden}), 32'b110111);
    check("index_after_reinit", 32'(pixel_index), 32'd0);
    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
